// File: rtl/layer_out_serializer.sv
// layer_out_serializer: collects skewed parallel neuron outputs, double-buffers them and streams lane 0..NN-1 with valid/ready.
module layer_out_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16,
    parameter int IDXW      = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NN-1:0]           in_valid_i,
    input  logic [NN*dataWidth-1:0] in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [dataWidth-1:0]    out_data_o,
    output logic [IDXW-1:0]         out_index_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    overflow_o
);
    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;
    logic                 state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [NN-1:0]        cmask_q, cmask_d, base, cap;
    logic                 ovf_q, ovf_d;
    logic                 cfull, hs, t;
    logic [dataWidth-1:0] cdata_q [NN];
    logic [dataWidth-1:0] sdata_q [NN];
    assign cfull       = &cmask_q;
    assign hs          = (state_q == SHIFT) && out_ready_i;
    assign out_last_o  = (state_q == SHIFT) && (idx_q == IDXW'(NN-1));
    assign t           = cfull && ((state_q == IDLE) || (hs && out_last_o));
    assign out_valid_o = (state_q == SHIFT);
    assign out_index_o = idx_q;
    assign out_data_o  = (state_q == SHIFT) ? sdata_q[idx_q] : '0;
    assign busy_o      = (|cmask_q) || (state_q == SHIFT);
    assign overflow_o  = ovf_q;
    // On a transfer edge the mask is cleared first, so strobes land in the fresh buffer.
    always_comb begin
        base    = t ? '0 : cmask_q;
        cap     = in_valid_i & ~base;
        cmask_d = base | in_valid_i;
        ovf_d   = ovf_q | (|(in_valid_i & base));
        state_d = t ? SHIFT : (hs && out_last_o) ? IDLE : state_q;
        idx_d   = (t || (hs && out_last_o)) ? '0 : hs ? idx_q + 1'b1 : idx_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cmask_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NN; i++) begin
                cdata_q[i] <= '0;
                sdata_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmask_q <= cmask_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < NN; i++) begin
                if (t) sdata_q[i] <= cdata_q[i];
                if (cap[i]) cdata_q[i] <= in_data_i[i*dataWidth +: dataWidth];
            end
        end
    end
endmodule

// File: tb/tb_layer_out_serializer.sv
// tb_layer_out_serializer: directed vectors for the NN=4 serializer with hand-computed expected words.
module tb_layer_out_serializer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic        out_valid, out_ready, out_last, busy, overflow;
    logic [15:0] out_data;
    logic [1:0]  out_index;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] ew [8];
    logic [63:0] vb;

    layer_out_serializer #(.NN(4), .dataWidth(16), .IDXW(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_index_o(out_index), .out_last_o(out_last), .busy_o(busy), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic strobe(input logic [3:0] m, input logic [63:0] d);
        in_valid = m;
        in_data  = d;
        @(negedge clk);
        in_valid = '0;
    endtask

    // Accepts n words against ew[], optionally with 1,0,0,1 backpressure or a mid-stream vector injection.
    task automatic drain(input int n, input bit bp, input bit inj);
        int k = 0;
        int cyc = 0;
        bit started = 0;
        bit held = 0;
        bit injd = 0;
        logic [15:0] hd = '0;
        logic [1:0]  hi = '0;
        logic [3:0]  pat = 4'b1001;
        while (k < n && cyc < 100) begin
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            in_valid  = '0;
            if (inj && k == 1 && !injd) begin
                in_valid = 4'hf;
                in_data  = vb;
                injd     = 1;
            end
            if (held) begin
                check("hold_data", out_data, hd);
                check("hold_index", out_index, hi);
            end
            if (started && !bp) check("gap", out_valid, 1);
            if (out_valid) started = 1;
            held = out_valid && !out_ready;
            hd   = out_data;
            hi   = out_index;
            if (out_valid && out_ready) begin
                check("data", out_data, ew[k]);
                check("index", out_index, k % 4);
                check("last", out_last, (k % 4) == 3);
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = '0;
        check("word_count", k, n);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        // basic single-cycle vector
        strobe(4'hf, {16'h0044, 16'h0033, 16'h0022, 16'h0011});
        check("t1_busy", busy, 1);
        check("t1_pre_valid", out_valid, 0);
        @(negedge clk);
        check("t1_latency", out_valid, 1);
        ew[0] = 16'h0011; ew[1] = 16'h0022; ew[2] = 16'h0033; ew[3] = 16'h0044;
        drain(4, 0, 0);
        check("t1_done", out_valid, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_ovf", overflow, 0);
        // skewed arrival 2,0,3,1
        strobe(4'b0100, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234});
        check("t2_wait2", out_valid, 0);
        strobe(4'b0001, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234});
        check("t2_wait0", out_valid, 0);
        strobe(4'b1000, {16'hDEF0, 16'hEEEE, 16'hEEEE, 16'hEEEE});
        check("t2_wait3", out_valid, 0);
        strobe(4'b0010, {16'h0000, 16'h0000, 16'h5678, 16'h0000});
        check("t2_wait1", out_valid, 0);
        @(negedge clk);
        check("t2_latency", out_valid, 1);
        ew[0] = 16'h1234; ew[1] = 16'h5678; ew[2] = 16'h9ABC; ew[3] = 16'hDEF0;
        drain(4, 0, 0);
        check("t2_ovf", overflow, 0);
        // backpressure
        strobe(4'hf, {16'hA004, 16'hA003, 16'hA002, 16'hA001});
        @(negedge clk);
        ew[0] = 16'hA001; ew[1] = 16'hA002; ew[2] = 16'hA003; ew[3] = 16'hA004;
        drain(4, 1, 0);
        check("t3_done", out_valid, 0);
        // back-to-back: B strobed while A sits at index 1
        strobe(4'hf, {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01});
        @(negedge clk);
        vb = {16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01};
        ew[0] = 16'h0A01; ew[1] = 16'h0A02; ew[2] = 16'h0A03; ew[3] = 16'h0A04;
        ew[4] = 16'h0B01; ew[5] = 16'h0B02; ew[6] = 16'h0B03; ew[7] = 16'h0B04;
        drain(8, 0, 1);
        check("t4_ovf", overflow, 0);
        check("t4_done", out_valid, 0);
        // overflow: lane 0 strobed twice
        strobe(4'b0001, {48'h0, 16'h0AAA});
        check("t5_ovf_pre", overflow, 0);
        strobe(4'b0001, {48'h0, 16'h0BBB});
        check("t5_ovf_set", overflow, 1);
        strobe(4'b1110, {16'h0D03, 16'h0D02, 16'h0D01, 16'h0BBB});
        @(negedge clk);
        ew[0] = 16'h0AAA; ew[1] = 16'h0D01; ew[2] = 16'h0D02; ew[3] = 16'h0D03;
        drain(4, 0, 0);
        check("t5_ovf_sticky", overflow, 1);
        // reset mid-shift
        strobe(4'hf, {16'h0C04, 16'h0C03, 16'h0C02, 16'h0C01});
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t6_index", out_index, 2);
        check("t6_data", out_data, 16'h0C03);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_rdata", out_data, 0);
        check("t6_rindex", out_index, 0);
        check("t6_rlast", out_last, 0);
        check("t6_busy", busy, 0);
        check("t6_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(4'hf, {16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01});
        @(negedge clk);
        ew[0] = 16'h0E01; ew[1] = 16'h0E02; ew[2] = 16'h0E03; ew[3] = 16'h0E04;
        drain(4, 0, 0);
        check("t6_done", out_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_out_serializer.md
# layer_out_serializer

Downstream stage of a fully-connected layer. Collects the NN parallel neuron outputs, tolerating per-neuron skew in their valid strobes, into a collection buffer. Once every lane has arrived, moves the vector into a shadow buffer and streams it out one value per cycle with a valid/ready handshake. The output stream is the serial `x_in`/`x_valid` feed of the next layer. Double buffering lets vector k+1 be collected while vector k is still shifting out.

## Interface
- `NN`, default 30: neurons in the producing layer; number of lanes.
- `dataWidth`, default 16: bits per neuron value.
- `IDXW`, default 5: width of `out_index`; must satisfy 2^IDXW >= NN.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `in_valid`  in  NN  per-lane strobe from the layer's `o_valid`; bit i qualifies lane i.
- `in_data`  in  NN*dataWidth  layer's `x_out`; lane i is `in_data[i*dataWidth +: dataWidth]`.
- `out_valid`  out  1  `out_data` holds a valid serial word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  dataWidth  current serial word.
- `out_index`  out  IDXW  lane number of `out_data`.
- `out_last`  out  1  current word is lane NN-1.
- `busy`  out  1  collection mask non-zero or `out_valid` high.
- `overflow`  out  1  sticky error flag; cleared only by reset.

## Operation
- Collection buffer: NN×dataWidth data registers plus an NN-bit mask `cmask`.
  - On an edge where `in_valid[i]`=1 and `cmask[i]`=0, capture lane i and set `cmask[i]`.
  - `cfull` = &`cmask`.
- Duplicate strobe: `in_valid[i]`=1 while `cmask[i]`=1, including any strobe while `cfull`=1.
  - Data is ignored, the stored value is kept, and `overflow` is set.
- Shadow/shift state machine, two states:
  - IDLE: `out_valid`=0.
  - SHIFT: `out_valid`=1, `out_data` = shadow[`out_index`].
- Transfer condition T = `cfull` && (IDLE || (SHIFT && `out_ready` && `out_last`)). On an edge with T:
  - Copy the collection buffer to the shadow buffer.
  - Clear `cmask`.
  - Set `out_index`=0 and enter or remain in SHIFT.
- Simultaneous strobes on a T edge: lanes with `in_valid`=1 are captured into the freshly cleared collection buffer. They set `cmask` and are not overflow.
- SHIFT handshake, on an edge with `out_ready`=1:
  - If `out_last`=0: `out_index` increments.
  - If `out_last`=1 and T=0: return to IDLE.
  - If `out_last`=1 and T=1: stay in SHIFT at index 0 with the new vector.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` hold stable.
- `out_last` = SHIFT && (`out_index` == NN-1).
- Output order is lane 0 first, lane NN-1 last. No arithmetic is performed on data; values pass bit-exact.

## Timing
- Reset (`rst`=0, asynchronous):
  - All outputs 0: `out_valid`, `out_data`, `out_index`, `out_last`, `busy`, `overflow`.
  - `cmask`=0; state IDLE.
  - Reset asserted mid-collection or mid-shift discards all data immediately.
- Release: first capture can occur on the first rising edge with `rst`=1.
- Latency: the edge that completes `cmask` is edge E. With IDLE at E, T is true at edge E+1 and `out_valid`=1 after E+1 with lane 0.
- Throughput: with `out_ready` held high, NN words in NN consecutive cycles. Back-to-back vectors need no bubble if the next vector is `cfull` before the last handshake.
- Flag timing:
  - `overflow` rises the cycle after the offending edge.
  - `busy` is combinational from registered state.

## Test plan
- NN=4, dataWidth=16. Release reset; assert `in_valid`=4'b1111 for one cycle with lanes 0x0011, 0x0022, 0x0033, 0x0044; `out_ready`=1.
  - Required: `out_valid` high 4 cycles starting 2 edges after the strobe.
  - Data 0x0011, 0x0022, 0x0033, 0x0044; `out_index` 0..3; `out_last` only on 0x0044; `overflow`=0.
- Skewed strobes: lanes arrive one per cycle in order 2, 0, 3, 1.
  - Required: no output until lane 1 is captured; then the 4 words in lane order 0..3.
- Backpressure: `out_ready` toggles 1,0,0,1,...
  - Required: each word held while `out_ready`=0; all 4 delivered once each, in order.
- Back-to-back: vector B fully strobed while vector A is at index 1.
  - Required: B's lane 0 appears the cycle after A's `out_last` handshake with no gap; `overflow`=0.
- Overflow: strobe lane 0 twice before the other lanes arrive, values 0x0AAA then 0x0BBB.
  - Required: `overflow`=1 from the next cycle; lane 0 later outputs 0x0AAA.
- Reset mid-shift: pull `rst` low while `out_index`=2.
  - Required: all outputs 0 immediately; a new vector after release streams correctly from lane 0.
